// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: defaults, stat widths,
// FIFO entry layout and the bridge hold-register state encoding.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int STAT_W        = 16;

  // FIFO entry is {tuser, last, data}; offsets are counted from bit DATA_BITS.
  localparam int ENT_LAST_OFS  = 0;
  localparam int ENT_TUSER_OFS = 1;
  localparam int ENT_EXTRA     = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } rx_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is visible the cycle after its push.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     push_ok,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign push_ok  = do_push;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, a push alongside a pop overwrites the departing head slot.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_axis_bridge.sv
// Turns receiver byte pulses into an AXI4-Stream, holding one byte back so the
// packet end (tlast) can be marked when the line goes idle; keeps error stats.
module uart_rx_axis_bridge
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = DATA_BITS_DEF,
  parameter int FIFO_DEPTH      = 16,
  parameter int IDLE_TIMEOUT    = 1000,
  parameter int DROP_PARITY_ERR = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  input  logic                          parity_error,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          clr_stats,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [STAT_W-1:0]             overflow_cnt,
  output logic [STAT_W-1:0]             parity_err_cnt
);

  localparam int EW = DATA_BITS + ENT_EXTRA;
  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

  rx_state_t            state, state_nxt;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_user;
  logic [TW-1:0]        timer;

  logic ev, ev_user;
  logic capture, timer_clr, timer_inc;
  logic push, push_last, push_ok, pop;
  logic fifo_full, fifo_empty;
  logic [EW-1:0] push_ent, head_ent;

  // With dropping enabled a parity failure suppresses the byte even if rx_valid is also high.
  assign ev      = (DROP_PARITY_ERR != 0) ? (rx_valid && !parity_error)
                                          : (rx_valid || parity_error);
  assign ev_user = (DROP_PARITY_ERR == 0) && parity_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (ev) begin
          capture   = 1'b1;
          timer_clr = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ev) begin
          push      = 1'b1;
          capture   = 1'b1;
          timer_clr = 1'b1;
        end else if (timer == TIMER_LAST) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_nxt = ST_EMPTY;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_user <= 1'b0;
      timer     <= '0;
    end else begin
      if (capture) begin
        hold_data <= rx_data;
        hold_user <= ev_user;
      end
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
    end
  end

  always_comb begin
    push_ent                             = '0;
    push_ent[DATA_BITS-1:0]              = hold_data;
    push_ent[DATA_BITS + ENT_LAST_OFS]   = push_last;
    push_ent[DATA_BITS + ENT_TUSER_OFS]  = hold_user;
  end

  assign pop = m_axis_tvalid && m_axis_tready;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .pop_data  (head_ent),
    .push_ok   (push_ok),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head storage is unreset, so stream fields are forced to zero while empty.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0   : head_ent[DATA_BITS-1:0];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : head_ent[DATA_BITS + ENT_LAST_OFS];
  assign m_axis_tuser  = fifo_empty ? 1'b0 : head_ent[DATA_BITS + ENT_TUSER_OFS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow       <= 1'b0;
      overflow_cnt   <= '0;
      parity_err_cnt <= '0;
    end else if (clr_stats) begin
      overflow       <= 1'b0;
      overflow_cnt   <= '0;
      parity_err_cnt <= '0;
    end else begin
      if (push && !push_ok) begin
        overflow     <= 1'b1;
        overflow_cnt <= sat_inc(overflow_cnt);
      end
      if (parity_error) parity_err_cnt <= sat_inc(parity_err_cnt);
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Drives two bridges (parity-drop and parity-forward) with directed and random
// byte pulses and compares every cycle against a packet-level reference model.
module tb_uart_rx_axis_bridge;

  localparam int DB = 8;
  localparam int FD = 4;
  localparam int IT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        parity_error = 1'b0;
  logic        tready = 1'b0;
  logic        clr_stats = 1'b0;

  logic [7:0]  tdata_v [2];
  logic        tvalid_v [2];
  logic        tlast_v [2];
  logic        tuser_v [2];
  logic [2:0]  cnt_v [2];
  logic        ovf_v [2];
  logic [15:0] ovc_v [2];
  logic [15:0] pec_v [2];

  always #5 clk = ~clk;

  uart_rx_axis_bridge #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .IDLE_TIMEOUT(IT), .DROP_PARITY_ERR(1)) u_drop (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
    .m_axis_tdata(tdata_v[0]), .m_axis_tvalid(tvalid_v[0]), .m_axis_tready(tready),
    .m_axis_tlast(tlast_v[0]), .m_axis_tuser(tuser_v[0]), .clr_stats(clr_stats),
    .fifo_count(cnt_v[0]), .overflow(ovf_v[0]), .overflow_cnt(ovc_v[0]), .parity_err_cnt(pec_v[0]));

  uart_rx_axis_bridge #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .IDLE_TIMEOUT(IT), .DROP_PARITY_ERR(0)) u_fwd (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
    .m_axis_tdata(tdata_v[1]), .m_axis_tvalid(tvalid_v[1]), .m_axis_tready(tready),
    .m_axis_tlast(tlast_v[1]), .m_axis_tuser(tuser_v[1]), .clr_stats(clr_stats),
    .fifo_count(cnt_v[1]), .overflow(ovf_v[1]), .overflow_cnt(ovc_v[1]), .parity_err_cnt(pec_v[1]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: entries are {tuser, last, data}; packets close IT cycles after the last event.
  logic [9:0] mq [2][FD];
  int   mhead [2];
  int   msize [2];
  bit   hvld [2];
  logic [7:0] hbyte [2];
  bit   huser [2];
  int   hev [2];
  bit   m_ovf [2];
  int   m_ovc [2];
  int   m_pec [2];
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [9:0] log0 [$];
  logic [9:0] log1 [$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; msize[k] = 0; hvld[k] = 0;
      m_ovf[k] = 0; m_ovc[k] = 0; m_pec[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit drop, ev, usr, pop, do_push, acc;
    logic [9:0] ent;
    drop = (k == 0);
    ev   = drop ? (rx_valid && !parity_error) : (rx_valid || parity_error);
    usr  = !drop && parity_error;
    pop  = (msize[k] > 0) && tready;
    do_push = 0;
    ent = '0;
    if (ev) begin
      if (hvld[k]) begin do_push = 1; ent = {huser[k], 1'b0, hbyte[k]}; end
      hvld[k] = 1; hbyte[k] = rx_data; huser[k] = usr; hev[k] = cyc;
    end else if (hvld[k] && (cyc - hev[k] == IT)) begin
      do_push = 1; ent = {huser[k], 1'b1, hbyte[k]}; hvld[k] = 0;
    end
    acc = do_push && ((msize[k] < FD) || pop);
    if (pop) begin mhead[k] = (mhead[k] + 1) % FD; msize[k]--; end
    if (acc) begin mq[k][(mhead[k] + msize[k]) % FD] = ent; msize[k]++; end
    if (clr_stats) begin
      m_ovf[k] = 0; m_ovc[k] = 0; m_pec[k] = 0;
    end else begin
      if (do_push && !acc) begin m_ovf[k] = 1; if (m_ovc[k] < 65535) m_ovc[k]++; end
      if (parity_error && m_pec[k] < 65535) m_pec[k]++;
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      for (int k = 0; k < 2; k++) model_step(k);
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [9:0] h;
    bit v;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        v = (msize[k] > 0);
        h = v ? mq[k][mhead[k]] : 10'h0;
        chk($sformatf("u%0d_tvalid", k), tvalid_v[k], v);
        chk($sformatf("u%0d_tdata", k), tdata_v[k], h[7:0]);
        chk($sformatf("u%0d_tlast", k), tlast_v[k], h[8]);
        chk($sformatf("u%0d_tuser", k), tuser_v[k], h[9]);
        chk($sformatf("u%0d_count", k), cnt_v[k], msize[k]);
        chk($sformatf("u%0d_ovf", k), ovf_v[k], m_ovf[k]);
        chk($sformatf("u%0d_ovc", k), ovc_v[k], m_ovc[k]);
        chk($sformatf("u%0d_pec", k), pec_v[k], m_pec[k]);
        if (tvalid_v[k] && tready && !rst) begin
          if (k == 0) log0.push_back({tuser_v[k], tlast_v[k], tdata_v[k]});
          else        log1.push_back({tuser_v[k], tlast_v[k], tdata_v[k]});
        end
      end
    end
  end

  function automatic logic [9:0] lg(input int k, input int i);
    if (k == 0) return (i < log0.size()) ? log0[i] : 10'h3ff;
    return (i < log1.size()) ? log1[i] : 10'h3ff;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [7:0] d, input bit v, input bit pe);
    rx_data = d; rx_valid = v; parity_error = pe;
    tick();
    rx_valid = 0; parity_error = 0;
  endtask

  initial begin
    int n;
    int rate;
    rst = 1;
    tick(3);
    rst = 0;
    mon_en = 1;
    chk("rst_tvalid", tvalid_v[0], 0);
    chk("rst_count", cnt_v[0], 0);

    // Three bytes, last closed by timeout 21 cycles after its pulse.
    tready = 1;
    log0.delete(); log1.delete();
    pulse(8'h41, 1, 0); tick(9);
    pulse(8'h42, 1, 0); tick(9);
    rx_data = 8'h43; rx_valid = 1;
    tick(); n = 1; rx_valid = 0;
    while (!(tvalid_v[0] && tdata_v[0] == 8'h43) && n < 100) begin tick(); n++; end
    chk("lat43", n, 21);
    tick(5);
    chk("s1_len", log0.size(), 3);
    chk("s1_b0", lg(0, 0), 10'h041);
    chk("s1_b1", lg(0, 1), 10'h042);
    chk("s1_b2", lg(0, 2), 10'h143);

    // Parity-failed byte: dropped by u_drop, forwarded with tuser by u_fwd.
    log0.delete(); log1.delete();
    pulse(8'h10, 1, 0); tick(4);
    pulse(8'h55, 0, 1); tick(4);
    pulse(8'h11, 1, 0); tick(30);
    chk("s2_drop_len", log0.size(), 2);
    chk("s2_drop_b0", lg(0, 0), 10'h010);
    chk("s2_drop_b1", lg(0, 1), 10'h111);
    chk("s2_drop_pec", pec_v[0], 1);
    chk("s2_fwd_len", log1.size(), 3);
    chk("s2_fwd_b0", lg(1, 0), 10'h010);
    chk("s2_fwd_b1", lg(1, 1), 10'h255);
    chk("s2_fwd_b2", lg(1, 2), 10'h111);
    chk("s2_fwd_pec", pec_v[1], 1);

    // Overflow with a stalled sink.
    tready = 0;
    clr_stats = 1; tick(); clr_stats = 0;
    for (int i = 0; i < 7; i++) begin pulse(8'(i), 1, 0); tick(4); end
    tick(30);
    chk("s3_ovf", ovf_v[0], 1);
    chk("s3_ovc", ovc_v[0], 3);
    chk("s3_count", cnt_v[0], 4);
    log0.delete(); log1.delete();
    tready = 1;
    tick(10);
    chk("s3_len", log0.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s3_b%0d", i), lg(0, i), 10'(i));

    // Event landing exactly in the timeout cycle keeps the packet open.
    log0.delete(); log1.delete();
    pulse(8'hA0, 1, 0); tick(19);
    pulse(8'hA1, 1, 0); tick(30);
    chk("s4_len", log0.size(), 2);
    chk("s4_b0", lg(0, 0), 10'h0A0);
    chk("s4_b1", lg(0, 1), 10'h1A1);

    // Asynchronous reset mid-packet with two queued entries.
    tready = 0;
    pulse(8'hB0, 1, 0); tick(2);
    pulse(8'hB1, 1, 0); tick(2);
    pulse(8'hB2, 1, 0); tick(2);
    chk("s5_pre_count", cnt_v[0], 2);
    #2; rst = 1; model_reset();
    #1;
    chk("s5_tvalid", tvalid_v[0], 0);
    chk("s5_count", cnt_v[0], 0);
    chk("s5_tdata", tdata_v[1], 0);
    chk("s5_ovf", ovf_v[0], 0);
    tick(2);
    rst = 0; tready = 1;
    log0.delete(); log1.delete();
    tick(40);
    chk("s5_no_out0", log0.size(), 0);
    chk("s5_no_out1", log1.size(), 0);

    // clr_stats in the same cycle as a rejected push.
    tready = 0;
    for (int i = 0; i < 5; i++) begin pulse(8'hC0 + 8'(i), 1, 0); tick(1); end
    rx_data = 8'hC5; rx_valid = 1; clr_stats = 1;
    tick();
    rx_valid = 0; clr_stats = 0;
    chk("s6_ovc", ovc_v[0], 0);
    chk("s6_ovf", ovf_v[0], 0);
    pulse(8'hC6, 1, 0);
    chk("s6_ovc_after", ovc_v[0], 1);
    tready = 1;
    tick(40);

    // Randomized traffic with varying density, sink stalls and stat clears.
    rate = 10;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rate = $urandom_range(0, 3) == 0 ? 60 : ($urandom_range(0, 1) ? 15 : 3);
      rx_data      = 8'($urandom);
      rx_valid     = ($urandom_range(0, 99) < rate);
      parity_error = ($urandom_range(0, 99) < 5);
      tready       = ($urandom_range(0, 99) < 70);
      clr_stats    = ($urandom_range(0, 99) < 1);
      tick();
    end
    rx_valid = 0; parity_error = 0; clr_stats = 0; tready = 1;
    tick(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis_bridge.md
# uart_rx_axis_bridge

Downstream stage of the UART receiver: accepts its one-cycle byte pulses (`rx_data`/`rx_valid`/`parity_error`) and presents them as an AXI4-Stream master. Buffers bytes in a FIFO and frames packets with `tlast` on line-idle timeout. Keeps sticky/saturating error statistics for the register block.

## Interface
- `DATA_BITS`, 8: byte width; must match the receiver.
- `FIFO_DEPTH`, 16: FIFO entries; power of 2, ≥2.
- `IDLE_TIMEOUT`, 1000: clk cycles with no new byte before the held byte is closed with `tlast`; ≥2.
- `DROP_PARITY_ERR`, 1: 1 = discard parity-failed bytes; 0 = forward them with `tuser`=1.
- Clocking/reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in DATA_BITS: byte from the receiver.
- `rx_valid` in 1: one-cycle pulse, good byte.
- `parity_error` in 1: one-cycle pulse, byte failed parity.
- `m_axis_tdata` out DATA_BITS: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: last byte of packet.
- `m_axis_tuser` out 1: byte had parity error; always 0 when DROP_PARITY_ERR=1.
- `clr_stats` in 1: synchronous clear of `overflow` and counters.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky, set when a FIFO write is lost.
- `overflow_cnt` out 16: lost writes, saturates at 16'hFFFF.
- `parity_err_cnt` out 16: parity_error pulses, saturates at 16'hFFFF.

## Operation
- Byte event: `rx_valid`=1, or `parity_error`=1 with DROP_PARITY_ERR=0. Both high in one cycle = one event, tuser=1 (parity wins).
- Every `parity_error` pulse increments `parity_err_cnt` regardless of DROP_PARITY_ERR.
- Hold register + FSM, states EMPTY and HOLD:
  - EMPTY + event: capture {tuser, data} into hold, idle timer := 0, -> HOLD.
  - HOLD + event: push hold to FIFO with last=0, capture new byte, timer := 0, stay HOLD.
  - HOLD, no event, timer == IDLE_TIMEOUT-1: push hold with last=1, -> EMPTY.
  - HOLD, no event otherwise: timer += 1.
  - An event in the timeout cycle wins: push with last=0, no tlast.
- FIFO entry {tuser, last, data}, first-word-fall-through; head drives `m_axis_*`.
- Pop when tvalid && tready. Push accepted if count < FIFO_DEPTH or a pop occurs in the same cycle.
- Rejected push: entry discarded, `overflow` := 1, `overflow_cnt` += 1 (saturating). The hold register still captures the new byte.
- `clr_stats` clears `overflow`, `overflow_cnt` and `parity_err_cnt`; it wins over a same-cycle increment.
- `tvalid` must not drop, and head contents must not change, until the entry is accepted.

## Timing
- Reset: state EMPTY, timer 0, FIFO empty, `m_axis_tvalid`=0, `tdata`/`tlast`/`tuser`=0, `fifo_count`=0, `overflow`=0, both counters 0. Hold content and FIFO content are lost mid-packet.
- Push in cycle N (registered): `fifo_count` and `m_axis_tvalid` update at N+1.
- Pop in cycle N: next head visible at N+1.
- A byte reaches the stream one cycle after the next byte event, or IDLE_TIMEOUT+1 cycles after its own event.
- `fifo_count` = pushes − pops; unchanged on simultaneous push and pop.
- Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty come from the count.

## Structure
- Shared package `uart_pkg`: default DATA_BITS, stat counter width (16), FIFO entry field offsets (tuser, last).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): FWFT, count output, push/pop/full/empty. FSM, timer and statistics stay in the top.

## Test plan
Bench parameters: FIFO_DEPTH=4, IDLE_TIMEOUT=20.
- Bytes 0x41, 0x42, 0x43 spaced 10 cycles, tready=1 -> stream 41/0, 42/0, 43/1 (data/tlast); 0x43 appears 21 cycles after its pulse.
- DROP_PARITY_ERR=1, pulses 0x10 good, 0x55 parity_error, 0x11 good -> stream 10, 11 only (11 with tlast); `parity_err_cnt`=1. Same stimulus with DROP_PARITY_ERR=0 -> 55 has tuser=1, `parity_err_cnt`=1.
- tready=0, 7 bytes 0x00–0x06 spaced 5 cycles, then idle -> 4 entries stored (00–03), writes of 04 and 05 rejected, 06 also rejected at timeout -> `overflow`=1, `overflow_cnt`=3, `fifo_count`=4. Then tready=1 -> 00–03 delivered with tlast=0.
- Byte event exactly at timer == IDLE_TIMEOUT-1 -> previous byte pushed with tlast=0; the new byte later closes the packet with tlast=1.
- Assert `rst` while HOLD with 2 entries in FIFO -> all outputs return to reset values immediately, no further stream output. Pulse `clr_stats` concurrent with an overflow -> counters read 0.
